// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: handshake bundle between the pipeline stages and the hazard controller
//   master: pipeline side, drives ID instruction, valid, branch and memory status
//   slave : hazard_ctrl side, returns stall/bubble/flush/freeze, forwarding selects and ready
interface hazard_ctrl_if;
  logic [15:0] instin;
  logic        id_valid;
  logic        branch_taken;
  logic        mem_ready;
  logic        pc_stall;
  logic        ifid_stall;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        freeze;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        ready;
  modport master (
    output instin, id_valid, branch_taken, mem_ready,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, freeze, fwd_a, fwd_b, ready
  );
  modport slave (
    input  instin, id_valid, branch_taken, mem_ready,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, freeze, fwd_a, fwd_b, ready
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 16-bit MIPS core
//   clk, reset (async, active-low), bus (hazard_ctrl_if.slave: ID instruction/valid,
//   branch_taken, mem_ready in; stall/bubble/flush/freeze, fwd_a/fwd_b, ready out).
//   Optional HAZARD_PERF_EN adds clr_cnt, stall_cnt and flush_cnt saturating counters.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int SAT_W        = 16
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
  ,
  input  logic             clr_cnt,
  output logic [SAT_W-1:0] stall_cnt,
  output logic [SAT_W-1:0] flush_cnt
`endif
);
  typedef enum logic [1:0] {RUN, LSTALL, FLUSH, MWAIT} state_t;
  typedef struct packed {
    logic       v;
    logic [2:0] dst;
    logic       ld;
    logic       mem;
  } ent_t;

  state_t     state_q, state_d, ret_q, ret_d;
  logic [1:0] cnt_q, cnt_d;
  ent_t       id_e, ex_q, mem_q, wb_q;
  logic [2:0] op, rs, rt, fn, id_dst;
  logic       use_rs, use_rt, lu, mw, in_flush, do_stall, do_flush;

  assign {op, rs, rt} = bus.instin[15:7];
  assign fn     = bus.instin[2:0];
  // shifts carry shamt in the rs field, so rs is not a real source for them
  assign use_rs = !(op == 3'd0 && (fn == 3'd0 || fn == 3'd7));
  assign use_rt = op inside {3'd0, 3'd4, 3'd5, 3'd7};
  assign id_dst = op == 3'd0 ? bus.instin[6:4] : op inside {3'd1, 3'd2, 3'd3, 3'd6} ? rt : 3'd0;
  assign id_e   = {bus.id_valid & ~bus.idex_bubble, id_dst, op == 3'd6, op[2] & op[1]};

  assign lu = bus.id_valid & ex_q.v & ex_q.ld & (ex_q.dst != 3'd0)
            & ((use_rs & (rs == ex_q.dst)) | (use_rt & (rt == ex_q.dst)));
  assign mw = ~bus.mem_ready & mem_q.v & mem_q.mem;
  // a flush paused by a memory wait resumes once the wait ends
  assign in_flush = (state_q == FLUSH) | (state_q == MWAIT && ret_q == FLUSH);
  assign do_flush = ~mw & in_flush;
  assign do_stall = ~mw & ~in_flush & lu;

  assign bus.freeze      = mw;
  assign bus.pc_stall    = mw | do_stall;
  assign bus.ifid_stall  = mw | do_stall;
  assign bus.idex_bubble = do_flush | do_stall;
  assign bus.ifid_flush  = do_flush;
  assign bus.ready       = ~(mw | do_flush | do_stall);

  function automatic logic [1:0] fwd_sel(input logic [2:0] r, input ent_t ex, input ent_t mem);
    return (ex.v && !ex.ld && ex.dst != 3'd0 && ex.dst == r) ? 2'b01 :
           (mem.v && mem.dst != 3'd0 && mem.dst == r) ? 2'b10 : 2'b00;
  endfunction

  assign bus.fwd_a = fwd_sel(rs, ex_q, mem_q);
  assign bus.fwd_b = fwd_sel(rt, ex_q, mem_q);

  always_comb begin
    state_d = mw ? MWAIT : bus.branch_taken ? FLUSH : in_flush ? (cnt_q == 2'd0 ? RUN : FLUSH) : lu ? LSTALL : RUN;
    ret_d   = mw ? (in_flush ? FLUSH : RUN) : ret_q;
    cnt_d   = mw ? cnt_q : bus.branch_taken ? 2'(FLUSH_CYCLES - 1) : (in_flush && cnt_q != 2'd0) ? cnt_q - 2'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      if (!mw) begin
        ex_q  <= id_e;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
    end

  // WB is tracked for completeness; the register file makes it visible without forwarding
  logic unused_bits;
  assign unused_bits = ^{bus.instin[3], wb_q};

`ifdef HAZARD_PERF_EN
  logic [SAT_W-1:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= clr_cnt ? '0 : stall_cnt_q + SAT_W'((do_stall | mw) & ~&stall_cnt_q);
      flush_cnt_q <= clr_cnt ? '0 : flush_cnt_q + SAT_W'(do_flush & ~&flush_cnt_q);
    end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic [SAT_W-1:0] unused_perf;
  assign unused_perf = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan sequences plus random traffic against a pipeline-level model
module tb_hazard_ctrl;
  localparam int FC = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if bus();
  hazard_ctrl #(.FLUSH_CYCLES(FC), .SAT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          v;
    logic [15:0] w;
  } slot_t;

  slot_t ex_m, mem_m, wb_m;
  int    flush_left;
  bit    e_frz, e_fl, e_st;

  function automatic logic [2:0] dst_of(input logic [15:0] w);
    case (w[15:13])
      3'd0:                    return w[6:4];
      3'd1, 3'd2, 3'd3, 3'd6: return w[9:7];
      default:                 return 3'd0;
    endcase
  endfunction

  function automatic bit reads(input logic [15:0] w, input logic [2:0] r);
    bit shift = w[15:13] == 3'd0 && (w[2:0] == 3'd0 || w[2:0] == 3'd7);
    return r != 3'd0 && ((!shift && w[12:10] == r) || (w[15:13] inside {3'd0, 3'd4, 3'd5, 3'd7} && w[9:7] == r));
  endfunction

  function automatic logic [1:0] fwd_of(input logic [2:0] r);
    if (ex_m.v && ex_m.w[15:13] != 3'd6 && dst_of(ex_m.w) != 3'd0 && dst_of(ex_m.w) == r) return 2'd1;
    if (mem_m.v && dst_of(mem_m.w) != 3'd0 && dst_of(mem_m.w) == r) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [7:0] ctl();
    return {2'b00, bus.pc_stall, bus.ifid_stall, bus.idex_bubble, bus.ifid_flush, bus.freeze, bus.ready};
  endfunction

  task automatic model_reset();
    ex_m = '{v: 1'b0, w: 16'h0};
    mem_m = ex_m;
    wb_m = ex_m;
    flush_left = 0;
  endtask

  task automatic step(input string tag, input logic [15:0] ins, input bit idv, input bit br, input bit mr);
    bus.instin = ins;
    bus.id_valid = idv;
    bus.branch_taken = br;
    bus.mem_ready = mr;
    @(negedge clk);
    e_frz = !mr && mem_m.v && mem_m.w[15:14] == 2'b11;
    e_fl = !e_frz && flush_left > 0;
    e_st = !e_frz && !e_fl && idv && ex_m.v && ex_m.w[15:13] == 3'd6 && reads(ins, dst_of(ex_m.w));
    check({tag, "_ctl"}, ctl(),
          {2'b00, e_frz | e_st, e_frz | e_st, e_fl | e_st, e_fl, e_frz, !(e_frz | e_fl | e_st)});
    check({tag, "_fwd"}, {4'b0, bus.fwd_a, bus.fwd_b}, {4'b0, fwd_of(ins[12:10]), fwd_of(ins[9:7])});
    @(posedge clk);
    if (!e_frz) begin
      flush_left = br ? FC : (flush_left > 0 ? flush_left - 1 : 0);
      wb_m = mem_m;
      mem_m = ex_m;
      ex_m = '{v: idv && !e_fl && !e_st, w: ins};
    end
    #1;
  endtask

  initial begin
    logic [15:0] w;
    model_reset();
    bus.instin = 16'h0;
    bus.id_valid = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ctl", ctl(), 8'b0000_0001);
    check("reset_fwd", {4'b0, bus.fwd_a, bus.fwd_b}, 8'h00);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step("lu_ld", 16'hC480, 1, 0, 1);
    step("lu_use", 16'h04A1, 1, 0, 1);
    step("lu_after", 16'h04A1, 1, 0, 1);
    step("alu_addi", 16'h2185, 1, 0, 1);
    step("alu_add", 16'h0C41, 1, 0, 1);
    step("sh_ld", 16'hC480, 1, 0, 1);
    step("sh_sll", 16'h0440, 1, 0, 1);
    step("br_pulse", 16'h0000, 1, 1, 1);
    step("br_flush", 16'h0000, 1, 0, 1);
    step("br_run", 16'h0000, 1, 0, 1);
    step("bl_ld", 16'hC480, 1, 0, 1);
    step("bl_stall", 16'h04A1, 1, 1, 1);
    step("bl_flush", 16'h04A1, 1, 0, 1);
    step("bl_run", 16'h04A1, 1, 0, 1);
    step("mw_ld", 16'hC480, 1, 0, 1);
    step("mw_nop", 16'h0000, 1, 0, 1);
    repeat (3) step("mw_wait", 16'h04A1, 1, 0, 0);
    step("mw_done", 16'h04A1, 1, 0, 1);
    step("ar_ld", 16'hC480, 1, 0, 1);
    step("ar_nop", 16'h0000, 1, 0, 1);
    step("ar_wait", 16'h0000, 1, 0, 0);
    bus.mem_ready = 1'b0;
    #1;
    check("ar_frozen", {7'b0, bus.freeze}, 8'h01);
    reset = 1'b0;
    #1;
    check("ar_ctl", ctl(), 8'b0000_0001);
    check("ar_fwd", {4'b0, bus.fwd_a, bus.fwd_b}, 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 600; i++) begin
      w = 16'($urandom) & 16'hEDBF;
      step("rand", w, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 16-bit MIPS core.
- Keeps a destination scoreboard for the EX, MEM and WB stages.
- Produces stall, bubble, flush and forwarding-select controls for IF, ID and EX.
- Drives the `ready` input of the decode stage, which gates R-type register write-enable.

Parameters:
- FLUSH_CYCLES, 1: bubble cycles inserted after a taken branch (1..3).
- SAT_W, 16: width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- instin  in  16  instruction currently in ID.
- id_valid  in  1  ID holds a real instruction (0 = bubble).
- branch_taken  in  1  taken branch or bne resolved in EX this cycle.
- mem_ready  in  1  data memory handshake; 0 while an lw/sw in MEM is pending.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold the IF/ID register.
- idex_bubble  out  1  load NOP into ID/EX.
- ifid_flush  out  1  clear IF/ID.
- freeze  out  1  hold every pipeline register (memory wait).
- fwd_a  out  2  ALU operand A select: 00 regfile, 01 EX result, 10 MEM result.
- fwd_b  out  2  ALU operand B select, same encoding.
- ready  out  1  to decode stage; 1 when ID may issue.

Behaviour:
- Decode of instin:
  - op = [15:13], rs = [12:10], rt = [9:7].
  - Destination is [6:4] for op 000 and rt for op 001/010/011/110. Other ops have no destination.
  - Register 0 is never a hazard.
- Source usage:
  - rs is used by all ops except op 000 with func[2:0] = 000 or 111 (shifts, where rs is the shamt).
  - rt is used by op 000, 100, 101 and 111 only.
- Scoreboard: three entries {valid, dst[2:0], is_load} for EX, MEM and WB.
  - Each cycle that freeze = 0, the entries shift EX→MEM→WB.
  - EX loads the ID entry, or invalid if idex_bubble = 1 or id_valid = 0.
  - When freeze = 1, all entries hold.
- FSM states: RUN, LSTALL, FLUSH, MWAIT.
  - MWAIT: enter when mem_ready = 0 and the MEM entry is lw or sw (sw is tracked by an is_mem bit). Stay while mem_ready = 0. Exit to the saved return state.
  - FLUSH: enter when branch_taken = 1. Stay for FLUSH_CYCLES cycles, counted by a down-counter, then go to RUN.
  - LSTALL: enter when the EX entry is a load, its dst ≠ 0, and dst matches a used source of ID. Stay exactly 1 cycle, then go to RUN.
- Priority: MWAIT > FLUSH > LSTALL > RUN. A branch during LSTALL goes to FLUSH, and the stalled ID instruction is discarded.
- Outputs (Moore from state plus combinational hazard detect, registered where stated):
  - RUN: all stall/flush outputs 0, ready = 1.
  - LSTALL: pc_stall = 1, ifid_stall = 1, idex_bubble = 1, ready = 0.
  - FLUSH: ifid_flush = 1, idex_bubble = 1, ready = 0.
  - MWAIT: freeze = 1, pc_stall = 1, ifid_stall = 1, ready = 0.
- Stall timing: the load-use stall asserts in the same cycle the hazard is visible (combinational). The FSM register captures it at the next posedge.
- Forwarding:
  - fwd_a = 01 if the EX entry is valid, not a load, and its dst matches rs (dst ≠ 0).
  - Otherwise 10 if the MEM entry matches.
  - Otherwise 00.
  - EX has priority over MEM. fwd_b uses rt in the same way.
  - WB never forwards: the register file writes on negedge, so the value is readable in the same cycle.
- Reset (reset = 0, asynchronous): state = RUN, scoreboard entries invalid, counter = 0. Outputs: all stall/flush/freeze = 0, fwd_a = fwd_b = 00, ready = 1.
- Reset mid-operation abandons any stall or flush immediately.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - Adds outputs stall_cnt[SAT_W-1:0], flush_cnt[SAT_W-1:0] and a clr_cnt input.
  - stall_cnt increments each cycle in LSTALL or MWAIT; flush_cnt increments each cycle in FLUSH.
  - Both counters saturate at all-ones. They clear on reset or when clr_cnt = 1 (clear wins over increment).
- When undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Load-use: ID = lw r1,0(r1) (0xC480), next ID = add r2,r1,r1 (0x04A1) → one cycle with pc_stall = ifid_stall = idex_bubble = 1 and ready = 0; following cycle fwd_a = fwd_b = 10.
- ALU forward: ID = addi r3,r0,5 (0x2185), next ID = add r4,r3,r0 (0x0C41) → no stall, fwd_a = 01, fwd_b = 00.
- Shift exemption: after lw r1, ID = sll with rs = 001 (0x0440) → no stall, fwd_a = 00.
- Branch: branch_taken pulses 1 cycle with FLUSH_CYCLES = 1 → ifid_flush = idex_bubble = 1 for exactly 1 cycle, then RUN.
- Branch during LSTALL → next state FLUSH, LSTALL cycle not repeated.
- Memory wait: lw in MEM, mem_ready = 0 for 3 cycles → freeze = 1 for 3 cycles, scoreboard unchanged, fwd outputs stable.
- Async reset asserted in MWAIT → outputs return to reset values without a clock edge.
